// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that shares one single-port synchronous RAM between NCORES cores.
// Supports a bounded grant hold, write-over-read priority and tagged read returns.
module mem_arbiter_rr #(
   parameter int NCORES   = 4,
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4,
   parameter int RD_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCORES-1:0]    rden,
   input  logic [NCORES-1:0]    wren,
   input  logic [NCORES*AW-1:0] addr,
   input  logic [NCORES*DW-1:0] din,
   input  logic [DW-1:0]        ram_q,
   output logic [NCORES-1:0]    acq,
   output logic [NCORES*DW-1:0] dq,
   output logic [NCORES-1:0]    dvalid,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_din,
   output logic                 ram_wren
);

   localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);

   logic [NCORES-1:0] req;
   logic [NCORES-1:0] others;
   logic              owner_vld;
   logic [IW-1:0]     owner;
   logic [IW-1:0]     last;
   logic [HW-1:0]     hold_cnt;
   logic              keep;
   logic              nxt_vld;
   logic [IW-1:0]     nxt;
   logic              issue;
   logic [RD_LAT:0]   rd_vld;
   logic [IW-1:0]     rd_tag [RD_LAT+1];

   assign req   = rden | wren;
   assign issue = nxt_vld & rden[nxt] & ~wren[nxt];

   // Keep the current owner unless its hold budget is spent and someone else is waiting;
   // otherwise search round-robin starting just after the last owner.
   always_comb begin
      int idx;
      idx    = 0;
      others = req;
      if (owner_vld) others[owner] = 1'b0;
      keep = owner_vld && req[owner] &&
             ((MAX_HOLD == 0) || (int'(hold_cnt) < MAX_HOLD) || (others == '0));
      nxt_vld = 1'b0;
      nxt     = owner;
      if (keep) begin
         nxt_vld = 1'b1;
      end else begin
         for (int off = 1; off <= NCORES; off++) begin
            idx = (int'(last) + off) % NCORES;
            if (!nxt_vld && req[idx]) begin
               nxt_vld = 1'b1;
               nxt     = IW'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_vld <= 1'b0;
         owner     <= '0;
         last      <= IW'(NCORES - 1);
         hold_cnt  <= '0;
         acq       <= '0;
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_wren  <= 1'b0;
      end else begin
         owner_vld <= nxt_vld;
         owner     <= nxt;
         acq       <= '0;
         ram_wren  <= 1'b0;
         if (nxt_vld) begin
            last      <= nxt;
            acq[nxt]  <= 1'b1;
            ram_addr  <= addr[nxt*AW +: AW];
            ram_din   <= din[nxt*DW +: DW];
            ram_wren  <= wren[nxt];
            // With unlimited hold the counter just sits at 1 while the owner is kept.
            if (keep) begin
               if ((MAX_HOLD != 0) && (int'(hold_cnt) < MAX_HOLD))
                  hold_cnt <= hold_cnt + 1'b1;
            end else begin
               hold_cnt <= HW'(1);
            end
         end else begin
            hold_cnt <= '0;
         end
      end
   end

   // Read tags travel alongside the RAM latency so returns land on the issuing core.
   always_ff @(posedge clk) begin
      rd_tag[0] <= nxt;
      for (int k = 1; k <= RD_LAT; k++)
         rd_tag[k] <= rd_tag[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld <= '0;
         dvalid <= '0;
         dq     <= '0;
      end else begin
         rd_vld <= {rd_vld[RD_LAT-1:0], issue};
         dvalid <= '0;
         if (rd_vld[RD_LAT]) begin
            dvalid[rd_tag[RD_LAT]]          <= 1'b1;
            dq[rd_tag[RD_LAT]*DW +: DW]     <= ram_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: read returns go through a scoreboard queue,
// grant/RAM-port behaviour is checked inline after each clock edge.
module tb_mem_arbiter_rr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rden = '0, wren = '0;
   logic [31:0] addr = '0, din = '0;
   logic [7:0]  ram_q;
   logic [3:0]  acq, dvalid;
   logic [31:0] dq;
   logic [7:0]  ram_addr, ram_din;
   logic        ram_wren;

   logic [3:0]  rden_h = '0, wren_h = '0;
   logic [31:0] addr_h = '0, din_h = '0;
   logic [7:0]  ram_q_h = '0;
   logic [3:0]  acq_h, dvalid_h;
   logic [31:0] dq_h;
   logic [7:0]  ram_addr_h, ram_din_h;
   logic        ram_wren_h;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         tag;
      logic [7:0] data;
      int         due;
   } exp_t;
   exp_t sb[$];

   logic [7:0] mem [256];

   mem_arbiter_rr #(.NCORES(4), .AW(8), .DW(8), .MAX_HOLD(4), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .rden(rden), .wren(wren), .addr(addr), .din(din),
      .ram_q(ram_q), .acq(acq), .dq(dq), .dvalid(dvalid), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_wren(ram_wren));

   mem_arbiter_rr #(.NCORES(4), .AW(8), .DW(8), .MAX_HOLD(0), .RD_LAT(1)) dut_h (
      .clk(clk), .rst(rst), .rden(rden_h), .wren(wren_h), .addr(addr_h), .din(din_h),
      .ram_q(ram_q_h), .acq(acq_h), .dq(dq_h), .dvalid(dvalid_h), .ram_addr(ram_addr_h),
      .ram_din(ram_din_h), .ram_wren(ram_wren_h));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle synchronous RAM, read-before-write.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
   end

   // Monitor: every dvalid pulse must match the oldest expected read return.
   always @(negedge clk) begin
      if (dvalid != 4'b0000) begin
         exp_t e;
         logic [3:0] exp_v;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_dvalid: dvalid=%b dq=%h, required no return", dvalid, dq);
         end else begin
            e = sb.pop_front();
            exp_v = 4'b0001 << e.tag;
            if (dvalid !== exp_v || dq[e.tag*8 +: 8] !== e.data || cyc != e.due) begin
               fails++;
               $display("[TB] FAIL read_return: dvalid=%b data=%h cycle=%0d, required dvalid=%b data=%h cycle=%0d",
                        dvalid, dq[e.tag*8 +: 8], cyc, exp_v, e.data, e.due);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_read(input int tag, input logic [7:0] data);
      exp_t e;
      e.tag  = tag;
      e.data = data;
      e.due  = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain_timeout: %0d returns outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[1] = 8'hA1;
      mem[2] = 8'hB2;

      // Reset state
      step(); step();
      check("rst_acq", {28'd0, acq}, 32'd0);
      check("rst_wren", {31'd0, ram_wren}, 32'd0);
      check("rst_dvalid", {28'd0, dvalid}, 32'd0);
      check("rst_dq", dq, 32'd0);
      rst = 1'b0;

      // Unlimited hold: core 1 keeps the grant until it drops, then core 2 at once
      rden_h = 4'b0110;
      for (int c = 0; c < 10; c++) begin
         step();
         check("t3_hold", {28'd0, acq_h}, 32'h2);
      end
      rden_h = 4'b0100;
      step();
      check("t3_switch", {28'd0, acq_h}, 32'h4);
      rden_h = 4'b0000;
      step();

      // Core 2 write then read back
      wren[2] = 1'b1; addr[16 +: 8] = 8'h10; din[16 +: 8] = 8'h5A;
      step();
      check("t1_acq_wr", {28'd0, acq}, 32'h4);
      check("t1_wren", {31'd0, ram_wren}, 32'd1);
      check("t1_ram_addr", {24'd0, ram_addr}, 32'h10);
      check("t1_ram_din", {24'd0, ram_din}, 32'h5A);
      wren[2] = 1'b0; rden[2] = 1'b1;
      step();
      expect_read(2, 8'h5A);
      check("t1_acq_rd", {28'd0, acq}, 32'h4);
      check("t1_wren_rd", {31'd0, ram_wren}, 32'd0);
      rden[2] = 1'b0;
      step();
      check("t1_idle", {28'd0, acq}, 32'd0);
      drain();
      check("t1_dq", {24'd0, dq[23:16]}, 32'h5A);

      // Cores 0 and 3 contend from reset: 4-cycle turns
      rst = 1'b1;
      wren = 4'b1001; addr = 32'h43000040; din = 32'h11000022;
      step();
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         check($sformatf("t2_grant_c%0d", c), {28'd0, acq},
               ((((c - 1) / 4) % 2) == 0) ? 32'h1 : 32'h8);
      end
      wren = 4'b0000;
      step();

      // Write wins over read when both are requested
      rden[1] = 1'b1; wren[1] = 1'b1; addr[8 +: 8] = 8'h20; din[8 +: 8] = 8'h33;
      step();
      check("t4_acq", {28'd0, acq}, 32'h2);
      check("t4_wren", {31'd0, ram_wren}, 32'd1);
      rden[1] = 1'b0; wren[1] = 1'b0;
      step(); step(); step();
      check("t4_no_dvalid", {28'd0, dvalid}, 32'd0);
      rden[1] = 1'b1;
      step();
      expect_read(1, 8'h33);
      rden[1] = 1'b0;
      drain();

      // Back-to-back reads from different cores
      rden[0] = 1'b1; addr[7:0] = 8'h01;
      step();
      expect_read(0, 8'hA1);
      check("t6_acq0", {28'd0, acq}, 32'h1);
      rden[0] = 1'b0; rden[1] = 1'b1; addr[15:8] = 8'h02;
      step();
      expect_read(1, 8'hB2);
      check("t6_acq1", {28'd0, acq}, 32'h2);
      rden[1] = 1'b0;
      drain();
      step();
      check("t6_dq", {16'd0, dq[15:0]}, 32'hB2A1);

      // Reset flushes an in-flight read and restores core 0 priority
      rden[0] = 1'b1; addr[7:0] = 8'h05;
      step();
      check("t5_acq0", {28'd0, acq}, 32'h1);
      rden[0] = 1'b0; wren[3] = 1'b1;
      step();
      check("t5_acq3", {28'd0, acq}, 32'h8);
      wren[3] = 1'b0; rst = 1'b1;
      step();
      check("t5_rst_acq", {28'd0, acq}, 32'd0);
      check("t5_rst_dq", dq, 32'd0);
      check("t5_rst_port", {15'd0, ram_wren, ram_addr, ram_din}, 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("t5_flushed", {28'd0, dvalid}, 32'd0);
      end
      wren = 4'b1001;
      step();
      check("t5_first", {28'd0, acq}, 32'h1);
      wren = 4'b0000;
      step(); step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
